instr_data_mem_ctrl: RTL
========================

Name: instr_data_mem_ctrl

Overview:
Parametrised unified instruction/data memory for the multi-cycle MIPS core, the successor of the single-array combinational-read memory.
- Byte-addressed with per-byte write enables.
- valid/ready request handshake and programmable wait states.
- Error reporting for misaligned, out-of-range and protected accesses.
- Hardware clear sequence for the data region after reset.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
INSTR_WORDS, 32, words in instruction region (word indices 0..INSTR_WORDS-1).
DATA_WORDS, 32, words in data region (indices INSTR_WORDS..INSTR_WORDS+DATA_WORDS-1).
ADDR_WIDTH, 32, byte address width.
WAIT_STATES, 1, extra cycles between accept and access; 0..15.
INSTR_WRITABLE, 1, 1 = instruction region writable (program load); 0 = writes there are errors.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller accepts request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  write data.
req_be  in  DATA_WIDTH/8  byte enables; bit i controls byte i (bits 8i+7:8i).
resp_valid  out  1  one-cycle response strobe.
resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
resp_err  out  1  access rejected; qualified by resp_valid.
init_done  out  1  data region clear sequence complete.

Behaviour:
- BOFF = log2(DATA_WIDTH/8). Word index = req_addr >> BOFF.
- Error conditions:
  - Misaligned: req_addr[BOFF-1:0] != 0.
  - Out of range: index >= INSTR_WORDS+DATA_WORDS.
  - Protected: INSTR_WRITABLE=0 and a write with index < INSTR_WORDS.
  - On any error the memory is unchanged, resp_err=1 and resp_rdata=0.
- While rst=1: state CLEAR, clear pointer = INSTR_WORDS. Outputs req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0. Instruction region contents are not touched by reset.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes 0 to the word at the clear pointer each cycle, then increments the pointer.
  - After the last data word it goes to IDLE; init_done=1 from then on.
  - Takes exactly DATA_WORDS cycles after rst deasserts.
- IDLE:
  - req_ready=1.
  - A transfer is accepted when req_valid and req_ready are both 1 (cycle T). we, index, wdata, be and error flags are latched.
  - WAIT_STATES>0: go to WAIT and load the wait counter with WAIT_STATES-1.
  - WAIT_STATES=0: go to RESP.
- WAIT:
  - req_ready=0. The counter decrements each cycle; at 0 the state goes to RESP.
- Access timing:
  - The access (read sample or write commit) happens at the clock edge ending cycle T+WAIT_STATES.
  - resp_valid=1 in cycle T+WAIT_STATES+1 for exactly one cycle, with registered resp_rdata/resp_err.
  - RESP returns to IDLE, so req_ready is 0 in RESP. Maximum throughput is one access per WAIT_STATES+2 cycles.
- Writes:
  - Only bytes with req_be=1 are updated.
  - be=0 is legal: no change, no error.
  - resp_rdata=0 for writes.
- Reads return the full word; be is ignored.
- Request inputs are ignored outside IDLE. There is no back-pressure on the response; the requester must sample resp_valid.
- Reset mid-operation (any state): the pending access is dropped and no resp_valid is produced. A write not yet committed is not performed. The CLEAR sequence restarts from INSTR_WORDS.
- rst deasserted during CLEAR does not shorten it: a full DATA_WORDS sweep always runs.

Decomposition:
- Package instr_data_mem_pkg:
  - state enum (CLEAR, IDLE, WAIT, RESP);
  - BOFF/index-width helper functions;
  - wait counter width constant (4 bits).
- Sub-module mem_bank_be:
  - DEPTH x DATA_WIDTH array;
  - one synchronous port with byte-enable write and registered read;
  - no reset on the array.
  - The controller muxes the clear writes and request accesses onto this port.

Test Plan:
- Clear: defaults, pulse rst, preload word 40 = 0x12345678 through the bench backdoor before reset → init_done rises exactly 32 cycles after rst falls; a read of 0xA0 returns 0x00000000.
- Full-word write/read: write 0x80 = 0xDEADBEEF, be=4'b1111; then read 0x80 → resp_valid exactly WAIT_STATES+1 cycles after each accept; rdata 0xDEADBEEF, err=0.
- Partial write: after the previous scenario, write 0x80 wdata 0x0000AA00 be=4'b0010; read 0x80 → 0xDEADAAEF.
- Misaligned and out-of-range:
  - read 0x82 → err=1, rdata 0;
  - write 0x100 (index 64) → err=1, no array change.
- Protection: INSTR_WRITABLE=0, word 0 preloaded 0x20080005; write 0x0 = 0xFFFFFFFF → err=1; a subsequent read of 0x0 returns 0x20080005.
- Reset mid-access: WAIT_STATES=3, write 0x84 = 0xCAFEF00D, assert rst in the 2nd WAIT cycle → no resp_valid; after init_done a read of 0x84 returns 0; instruction word 0 is retained.

Source files
------------

// File: rtl/instr_data_mem_pkg.sv
// Shared types and sizing helpers for the unified instruction/data memory controller.
package instr_data_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int unsigned WAIT_CNT_W = 4;

    // Byte-offset bits within one word.
    function automatic int unsigned boff(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Word-index width for a memory of the given depth.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_data_mem_ctrl_mem_bank_be.sv
// Single-port word array with per-byte write enables and a registered read.
module mem_bank_be #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AW         = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array carries no reset so instruction contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register holds zero except in the cycle after a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= (en_i && !we_i) ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_data_mem_ctrl.sv
// Request/response controller for the unified instruction/data memory:
// wait states, error checks and post-reset clearing of the data region.
module instr_data_mem_ctrl
    import instr_data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INSTR_WORDS    = 32,
    parameter int unsigned DATA_WORDS     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WAIT_STATES    = 1,
    parameter bit          INSTR_WRITABLE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    init_done
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned BOFF   = boff(DATA_WIDTH);
    localparam int unsigned DEPTH  = INSTR_WORDS + DATA_WORDS;
    localparam int unsigned IW     = idx_width(DEPTH);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic                    we_q, we_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NBYTES-1:0]       be_q, be_d;
    logic                    err_q, err_d;
    logic                    ready_q, resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d, init_done_q;

    logic [ADDR_WIDTH-1:0]   idx_full_c;
    logic                    req_err_c, accept_c;
    logic                    acc_we_c, acc_err_c;
    logic [IW-1:0]           acc_idx_c;
    logic [DATA_WIDTH-1:0]   acc_wdata_c;
    logic [NBYTES-1:0]       acc_be_c;

    logic                    mem_en_c, mem_we_c;
    logic [IW-1:0]           mem_addr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;
    logic [NBYTES-1:0]       mem_be_c;

    // Request decode: misaligned, out of range, or write to a protected instruction word.
    always_comb begin
        idx_full_c = req_addr >> BOFF;
        req_err_c  = ((req_addr & ADDR_WIDTH'(NBYTES - 1)) != '0)
                   || (idx_full_c >= ADDR_WIDTH'(DEPTH))
                   || (!INSTR_WRITABLE && req_we && (idx_full_c < ADDR_WIDTH'(INSTR_WORDS)));
        accept_c   = req_valid && ready_q;
    end

    // With no wait states the access uses the live request, otherwise the latched one.
    always_comb begin
        acc_we_c    = we_q;
        acc_idx_c   = idx_q;
        acc_wdata_c = wdata_q;
        acc_be_c    = be_q;
        acc_err_c   = err_q;
        if (state_q == ST_IDLE) begin
            acc_we_c    = req_we;
            acc_idx_c   = IW'(idx_full_c);
            acc_wdata_c = req_wdata;
            acc_be_c    = req_be;
            acc_err_c   = req_err_c;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = ptr_q;
        mem_wdata_c  = '0;
        mem_be_c     = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_en_c = 1'b1;
                mem_we_c = 1'b1;
                mem_be_c = '1;
                ptr_d    = ptr_q + IW'(1);
                if (ptr_q == IW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept_c) begin
                    we_d    = req_we;
                    idx_d   = IW'(idx_full_c);
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_err_c;
                    if (WAIT_STATES == 0) begin
                        state_d      = ST_RESP;
                        mem_en_c     = !acc_err_c;
                        mem_we_c     = acc_we_c;
                        mem_addr_c   = acc_idx_c;
                        mem_wdata_c  = acc_wdata_c;
                        mem_be_c     = acc_be_c;
                        resp_valid_d = 1'b1;
                        resp_err_d   = acc_err_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    mem_en_c     = !acc_err_c;
                    mem_we_c     = acc_we_c;
                    mem_addr_c   = acc_idx_c;
                    mem_wdata_c  = acc_wdata_c;
                    mem_be_c     = acc_be_c;
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err_c;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            ptr_q        <= IW'(INSTR_WORDS);
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            err_q        <= err_d;
            ready_q      <= (state_d == ST_IDLE);
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            init_done_q  <= init_done_q || (state_d != ST_CLEAR);
        end
    end

    mem_bank_be #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (IW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mem_en_c),
        .we_i    (mem_we_c),
        .addr_i  (mem_addr_c),
        .wdata_i (mem_wdata_c),
        .be_i    (mem_be_c),
        .rdata_o (resp_rdata)
    );

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign init_done  = init_done_q;

endmodule
